// File: rtl/elastic_fifo.sv
// Elastic FIFO: registered-output queue with occupancy-based handshake.
// Outputs depend only on state, so no combinational path from ins to outs.
module elastic_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] ins,
    input  logic                  ins_valid,
    output logic                  ins_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic                  outs_valid,
    input  logic                  outs_ready
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);
    localparam logic [CntW-1:0] OneCnt  = CntW'(1);
    localparam logic [PtrW-1:0] OnePtr  = PtrW'(1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]       count_q, count_d;
    logic                  push, pop;

    assign ins_ready  = (count_q != FullCnt);
    assign outs_valid = (count_q != '0);
    assign outs       = mem_q[rd_ptr_q];

    assign push = ins_valid & ins_ready;
    assign pop  = outs_valid & outs_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + OnePtr;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + OnePtr;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + OneCnt;
            2'b01:   count_d = count_q - OneCnt;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately not reset; it is only visible when outs_valid is high.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= ins;
        end
    end

endmodule

// File: tb/tb_elastic_fifo.sv
// Directed self-checking bench for elastic_fifo (DEPTH=4 and DEPTH=3 instances).
module tb_elastic_fifo;

    logic        clk;
    logic        rst;
    logic [31:0] ins, outs;
    logic        ins_valid, ins_ready, outs_valid, outs_ready;
    logic [31:0] ins3, outs3;
    logic        ins_valid3, ins_ready3, outs_valid3, outs_ready3;

    int checks;
    int errors;

    elastic_fifo #(.DATA_WIDTH(32), .DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .ins        (ins),
        .ins_valid  (ins_valid),
        .ins_ready  (ins_ready),
        .outs       (outs),
        .outs_valid (outs_valid),
        .outs_ready (outs_ready)
    );

    elastic_fifo #(.DATA_WIDTH(32), .DEPTH(3)) dut3 (
        .clk        (clk),
        .rst        (rst),
        .ins        (ins3),
        .ins_valid  (ins_valid3),
        .ins_ready  (ins_ready3),
        .outs       (outs3),
        .outs_valid (outs_valid3),
        .outs_ready (outs_ready3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) step();
        checks++;
        if (outs_valid !== 1'b0 || ins_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_hold: outs_valid=%b ins_ready=%b, want 0/1", outs_valid, ins_ready);
        end
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (outs_valid !== 1'b0 || ins_ready !== 1'b1 || outs_valid3 !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle[%0d]: outs_valid=%b ins_ready=%b outs_valid3=%b, want 0/1/0",
                         i, outs_valid, ins_ready, outs_valid3);
            end
        end
    endtask

    task automatic test_single();
        ins = 32'h0000_00A5;
        ins_valid = 1'b1;
        outs_ready = 1'b1;
        step();
        ins_valid = 1'b0;
        checks++;
        if (outs_valid !== 1'b1 || outs !== 32'h0000_00A5) begin
            errors++;
            $display("FAIL single_latency: outs_valid=%b outs=%h, want 1/000000a5", outs_valid, outs);
        end
        step();
        checks++;
        if (outs_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_pop: outs_valid=%b, want 0", outs_valid);
        end
    endtask

    task automatic test_fill();
        int n;
        outs_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            ins = i;
            ins_valid = 1'b1;
            step();
            checks++;
            if (outs_valid !== 1'b1 || outs !== 32'd1) begin
                errors++;
                $display("FAIL fill_head[%0d]: outs_valid=%b outs=%0d, want 1/1", i, outs_valid, outs);
            end
        end
        ins = 32'd5;
        checks++;
        if (ins_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_full: ins_ready=%b, want 0", ins_ready);
        end
        step();
        checks++;
        if (ins_ready !== 1'b0 || outs !== 32'd1) begin
            errors++;
            $display("FAIL fill_hold: ins_ready=%b outs=%0d, want 0/1", ins_ready, outs);
        end
        outs_ready = 1'b1;
        n = 0;
        for (int cyc = 0; cyc < 12 && n < 5; cyc++) begin
            logic pushing;
            if (outs_valid) begin
                checks++;
                if (outs !== n + 1) begin
                    errors++;
                    $display("FAIL fill_order[%0d]: outs=%0d, want %0d", n, outs, n + 1);
                end
                n++;
            end
            pushing = ins_valid & ins_ready;
            step();
            if (pushing) ins_valid = 1'b0;
            if (cyc == 0) begin
                checks++;
                if (ins_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL fill_ready_after_pop: ins_ready=%b, want 1", ins_ready);
                end
            end
        end
        ins_valid = 1'b0;
        checks++;
        if (n != 5 || outs_valid !== 1'b0) begin
            errors++;
            $display("FAIL fill_drain: popped=%0d outs_valid=%b, want 5/0", n, outs_valid);
        end
    endtask

    task automatic test_wrap();
        int k, exp_v;
        k = 0;
        exp_v = 0;
        ins3 = 32'd0;
        ins_valid3 = 1'b1;
        outs_ready3 = 1'b1;
        for (int cyc = 0; cyc < 30 && exp_v < 10; cyc++) begin
            logic pushing;
            checks++;
            if (ins_ready3 !== 1'b1) begin
                errors++;
                $display("FAIL wrap_ready[%0d]: ins_ready=%b, want 1", cyc, ins_ready3);
            end
            if (outs_valid3) begin
                checks++;
                if (outs3 !== exp_v) begin
                    errors++;
                    $display("FAIL wrap_order[%0d]: outs=%0d, want %0d", exp_v, outs3, exp_v);
                end
                exp_v++;
            end
            pushing = ins_valid3 & ins_ready3;
            step();
            if (pushing) begin
                k++;
                if (k == 10) ins_valid3 = 1'b0;
                else ins3 = k;
            end
        end
        ins_valid3 = 1'b0;
        checks++;
        if (exp_v != 10 || outs_valid3 !== 1'b0) begin
            errors++;
            $display("FAIL wrap_count: popped=%0d outs_valid=%b, want 10/0", exp_v, outs_valid3);
        end
    endtask

    task automatic test_full_simul();
        logic [31:0] exp_q [4];
        exp_q = '{32'd2, 32'd3, 32'd4, 32'd9};
        outs_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            ins = i;
            ins_valid = 1'b1;
            step();
        end
        ins = 32'd9;
        outs_ready = 1'b1;
        step();
        outs_ready = 1'b0;
        checks++;
        if (outs !== 32'd2 || ins_ready !== 1'b1) begin
            errors++;
            $display("FAIL simul_pop: outs=%0d ins_ready=%b, want 2/1", outs, ins_ready);
        end
        step();
        ins_valid = 1'b0;
        checks++;
        if (ins_ready !== 1'b0 || outs !== 32'd2) begin
            errors++;
            $display("FAIL simul_push: ins_ready=%b outs=%0d, want 0/2", ins_ready, outs);
        end
        outs_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (outs_valid !== 1'b1 || outs !== exp_q[i]) begin
                errors++;
                $display("FAIL simul_drain[%0d]: outs_valid=%b outs=%0d, want 1/%0d",
                         i, outs_valid, outs, exp_q[i]);
            end
            step();
        end
        checks++;
        if (outs_valid !== 1'b0) begin
            errors++;
            $display("FAIL simul_empty: outs_valid=%b, want 0", outs_valid);
        end
    endtask

    task automatic test_reset_mid();
        outs_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            ins = 32'h11 * i;
            ins_valid = 1'b1;
            step();
        end
        ins_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        checks++;
        if (outs_valid !== 1'b0 || ins_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_async: outs_valid=%b ins_ready=%b, want 0/1", outs_valid, ins_ready);
        end
        #2 rst = 1'b1;
        step();
        ins = 32'h77;
        ins_valid = 1'b1;
        outs_ready = 1'b1;
        step();
        ins_valid = 1'b0;
        checks++;
        if (outs_valid !== 1'b1 || outs !== 32'h77) begin
            errors++;
            $display("FAIL reset_first: outs_valid=%b outs=%h, want 1/77", outs_valid, outs);
        end
        step();
        checks++;
        if (outs_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_after: outs_valid=%b, want 0", outs_valid);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        ins = '0;
        ins_valid = 1'b0;
        outs_ready = 1'b0;
        ins3 = '0;
        ins_valid3 = 1'b0;
        outs_ready3 = 1'b0;
        #1;
        test_reset();
        test_single();
        test_fill();
        test_wrap();
        test_full_simul();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/elastic_fifo.md
ELASTIC_FIFO -- requirements
Module: elastic_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of the data token.
REQ-002 SHALL have parameter DEPTH, default 4, number of storage slots; legal range 2..64, any integer (not restricted to powers of two).
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst  input  1  asynchronous active-low reset (0 = reset).
REQ-006 SHALL have port ins  input  DATA_WIDTH  upstream data (driven by a selector result or any elastic producer).
REQ-007 SHALL have port ins_valid  input  1  upstream token present.
REQ-008 SHALL have port ins_ready  output  1  FIFO can accept a token this cycle.
REQ-009 SHALL have port outs  output  DATA_WIDTH  head-of-queue data.
REQ-010 SHALL have port outs_valid  output  1  head token present.
REQ-011 SHALL have port outs_ready  input  1  downstream accepts head token.

Function
REQ-012 SHALL transfer a token on ins when ins_valid & ins_ready at a rising clk edge (push), and on outs when outs_valid & outs_ready (pop).
REQ-013 SHALL hold state in a write pointer, read pointer (0..DEPTH-1) and occupancy count (0..DEPTH, width clog2(DEPTH+1)).
REQ-014 SHALL drive ins_ready = (count != DEPTH), a pure function of registered state; ins_ready SHALL NOT depend combinationally on outs_ready or ins_valid.
REQ-015 SHALL drive outs_valid = (count != 0) and outs = storage[read pointer], both functions of registered state only; no combinational path from ins to outs (non-transparent).
REQ-016 SHALL have minimum latency of one cycle: a token pushed at edge N is first visible on outs with outs_valid=1 after edge N, even when the FIFO was empty.
REQ-017 On push: write ins into storage[write pointer]; write pointer increments, wrapping from DEPTH-1 to 0.
REQ-018 On pop: read pointer increments, wrapping from DEPTH-1 to 0.
REQ-019 Count update: push only +1; pop only -1; push and pop in the same cycle -> unchanged; neither -> unchanged.
REQ-020 Full (count=DEPTH): ins_ready=0; a simultaneous pop frees one slot, ins_ready returns to 1 the following cycle; no push accepted in the full cycle.
REQ-021 Empty (count=0): outs_valid=0; no pop can occur; a push in the same cycle makes outs_valid=1 next cycle.
REQ-022 While outs_valid=1 and outs_ready=0, outs SHALL remain stable cycle to cycle regardless of concurrent pushes.
REQ-023 Tokens SHALL exit in exactly the order accepted; no token lost, duplicated or reordered across pointer wrap-around.
REQ-024 ins_valid asserted while ins_ready=0 SHALL have no effect on state; the producer holds its token.
REQ-025 outs value while outs_valid=0 is don't-care.

Reset
REQ-026 While rst=0 (asynchronously on assertion, independent of clk): write pointer=0, read pointer=0, count=0, hence outs_valid=0 and ins_ready=1.
REQ-027 Storage array SHALL NOT be reset; its content is unspecified after reset and never observable with outs_valid=1.
REQ-028 Reset asserted mid-operation SHALL discard all stored tokens; the first token pushed after rst returns to 1 is the first popped.
REQ-029 No push or pop SHALL occur on a clk edge while rst=0.

Verification
REQ-030 Reset then idle: rst=0 for 3 cycles, release -> outs_valid=0, ins_ready=1, count=0 held indefinitely with ins_valid=0.
REQ-031 Single token latency (DEPTH=4): push 0x0000_00A5 at edge N with outs_ready=1 -> outs_valid=1, outs=0x0000_00A5 after edge N, popped at edge N+1, outs_valid=0 after it.
REQ-032 Fill and back-pressure (DEPTH=4): outs_ready=0, push 1,2,3,4 -> ins_ready=0 after 4th edge; 5th token (5) held by producer; raise outs_ready -> outputs 1,2,3,4,5 in order, ins_ready=1 the cycle after first pop.
REQ-033 Wrap-around (DEPTH=3, non-power-of-two): continuous push and pop of 0..9 with outs_ready=1 -> output sequence 0..9, pointers wrap 2->0, count never exceeds 2.
REQ-034 Simultaneous push/pop at full (DEPTH=4, holding 1..4): ins_valid=1 (token 9), outs_ready=1 in one cycle -> 1 popped, 9 not accepted, count=3; next cycle 9 accepted, count=4.
REQ-035 Reset mid-stream: 3 tokens stored, pulse rst=0 between clk edges -> outs_valid=0 immediately; after release push 0x77 -> first output 0x77.
